// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary PE (pe_os_tile, pe_mac_unit).
package pe_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } pe_state_e;

    // Width of the full, unextended operand product.
    function automatic int unsigned prod_width(input int unsigned data_width);
        return 2 * data_width;
    endfunction

    // The accumulator must hold at least one full product.
    function automatic bit acc_width_ok(input int unsigned data_width,
                                        input int unsigned acc_width);
        return acc_width >= prod_width(data_width);
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply, extend and accumulate; saturating when PE_SAT_EN is defined.
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic                  clear,
    output logic [ACC_WIDTH-1:0]  sum_c
`ifdef PE_SAT_EN
    ,
    output logic                  sat_c
`endif
);

    localparam int unsigned PW = prod_width(DATA_WIDTH);

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] base;

    if (SIGNED) begin : g_signed
        logic signed [PW-1:0] prod;
        assign prod     = PW'($signed(a)) * PW'($signed(b));
        assign prod_ext = ACC_WIDTH'(prod);
    end else begin : g_unsigned
        logic [PW-1:0] prod;
        assign prod     = PW'(a) * PW'(b);
        assign prod_ext = ACC_WIDTH'(prod);
    end

    // A fresh tile starts from zero so the first beat cannot overflow.
    assign base = clear ? '0 : acc_in;

`ifdef PE_SAT_EN
    logic [ACC_WIDTH:0] sum_w;

    always_comb begin
        sum_w = {1'b0, base} + {1'b0, prod_ext};
        sum_c = sum_w[ACC_WIDTH-1:0];
        sat_c = 1'b0;
        if (SIGNED) begin
            if ((base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                (sum_w[ACC_WIDTH-1] != base[ACC_WIDTH-1])) begin
                sat_c = 1'b1;
                sum_c = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else if (sum_w[ACC_WIDTH]) begin
            sat_c = 1'b1;
            sum_c = '1;
        end
    end
`else
    assign sum_c = base + prod_ext;
`endif

endmodule

// File: rtl/pe_os_tile.sv
// Output-stationary systolic PE: operand forwarding, tile-depth MAC FSM and a one-deep result buffer.
// Optional build macro PE_SAT_EN: saturating accumulation plus a sat_flag output.
module pe_os_tile
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned K_WIDTH    = 8,
    parameter bit          SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] top_in,
    input  logic                  top_valid,
    input  logic [DATA_WIDTH-1:0] left_in,
    input  logic                  left_valid,
    input  logic [K_WIDTH-1:0]    k_len,
    output logic [DATA_WIDTH-1:0] bottom_out,
    output logic                  bottom_valid,
    output logic [DATA_WIDTH-1:0] right_out,
    output logic                  right_valid,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic                  overrun
`ifdef PE_SAT_EN
    ,
    output logic                  sat_flag
`endif
);

    if (!acc_width_ok(DATA_WIDTH, ACC_WIDTH)) begin : g_cfg_err
        $error("pe_os_tile: ACC_WIDTH must be >= 2*DATA_WIDTH");
    end

    pe_state_e            state, state_nxt;
    logic [K_WIDTH-1:0]   cnt, cnt_nxt;
    logic [K_WIDTH-1:0]   len, len_nxt;
    logic [K_WIDTH-1:0]   k_eff_c;
    logic [ACC_WIDTH-1:0] acc, acc_nxt;
    logic [ACC_WIDTH-1:0] result_nxt;
    logic                 result_valid_nxt;
    logic                 overrun_nxt;
    logic                 fire_c;
    logic                 done_c;
    logic                 mac_clear_c;
    logic [ACC_WIDTH-1:0] mac_sum_c;
`ifdef PE_SAT_EN
    logic                 mac_sat_c;
    logic                 tile_sat, tile_sat_nxt;
    logic                 sat_flag_nxt;
`endif

    assign fire_c  = top_valid & left_valid;
    assign k_eff_c = (k_len == '0) ? K_WIDTH'(1) : k_len;
    assign busy    = (state == ST_ACC);

    pe_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SIGNED     (SIGNED)
    ) u_mac (
        .a      (top_in),
        .b      (left_in),
        .acc_in (acc),
        .clear  (mac_clear_c),
        .sum_c  (mac_sum_c)
`ifdef PE_SAT_EN
        ,
        .sat_c  (mac_sat_c)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Tile sequencing and result buffer update.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        len_nxt          = len;
        acc_nxt          = acc;
        mac_clear_c      = 1'b0;
        done_c           = 1'b0;
        result_nxt       = result;
        result_valid_nxt = result_valid;
        overrun_nxt      = overrun;
`ifdef PE_SAT_EN
        tile_sat_nxt     = tile_sat;
        sat_flag_nxt     = sat_flag;
`endif

        unique case (state)
            ST_IDLE: begin
                mac_clear_c = 1'b1;
                if (fire_c) begin
                    acc_nxt = mac_sum_c;
                    cnt_nxt = K_WIDTH'(1);
                    len_nxt = k_eff_c;
`ifdef PE_SAT_EN
                    tile_sat_nxt = mac_sat_c;
`endif
                    if (k_eff_c == K_WIDTH'(1)) done_c = 1'b1;
                    else                        state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (fire_c) begin
                    acc_nxt = mac_sum_c;
                    cnt_nxt = cnt + K_WIDTH'(1);
`ifdef PE_SAT_EN
                    tile_sat_nxt = tile_sat | mac_sat_c;
`endif
                    if ((cnt + K_WIDTH'(1)) == len) begin
                        done_c    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A completion may refill the buffer in the same cycle it drains.
        if (result_valid && result_ready) result_valid_nxt = 1'b0;
        if (done_c) begin
            if (!result_valid || result_ready) begin
                result_nxt       = mac_sum_c;
                result_valid_nxt = 1'b1;
`ifdef PE_SAT_EN
                sat_flag_nxt     = tile_sat_nxt;
`endif
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            len          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef PE_SAT_EN
            tile_sat     <= 1'b0;
            sat_flag     <= 1'b0;
`endif
        end else begin
            cnt          <= cnt_nxt;
            len          <= len_nxt;
            acc          <= acc_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            overrun      <= overrun_nxt;
`ifdef PE_SAT_EN
            tile_sat     <= tile_sat_nxt;
            sat_flag     <= sat_flag_nxt;
`endif
        end
    end

    // Neighbour forwarding runs every cycle regardless of the MAC state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bottom_out   <= '0;
            bottom_valid <= 1'b0;
            right_out    <= '0;
            right_valid  <= 1'b0;
        end else begin
            bottom_valid <= top_valid;
            right_valid  <= left_valid;
            if (top_valid)  bottom_out <= top_in;
            if (left_valid) right_out  <= left_in;
        end
    end

endmodule
